// File: rtl/instr_queue_p.sv
// instr_queue_p: circular instruction queue between fetch and Tomasulo issue.
// Supports simultaneous push/pop, occupancy count, almost-full warning,
// flush for branch recovery, and sticky overflow/underflow error flags.
module instr_queue_p #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      flush,
    input  logic                      adc,
    input  logic                      rtr,
    input  logic [DATA_W-1:0]         instrIn,
    output logic [DATA_W-1:0]         instrOut,
    output logic                      outValid,
    output logic [DATA_W-1:0]         instrHead,
    output logic [$clog2(DEPTH):0]    ocup,
    output logic                      cheio,
    output logic                      vazio,
    output logic                      quase_cheio,
    output logic                      ovf,
    output logic                      udf
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCUP_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  frente;
    logic [PTR_W-1:0]  tras;
    logic              rtr_ok;
    logic              push_ok;
    logic              active;

    // Status flags come only from the occupancy counter, so a full queue and
    // an empty queue are never confused when the pointers coincide.
    always_comb begin
        cheio       = (ocup == OCUP_W'(DEPTH));
        vazio       = (ocup == '0);
        quase_cheio = (ocup >= OCUP_W'(AF_LEVEL));
        instrHead   = vazio ? '0 : mem[frente];
    end

    // Accept logic: a pop frees a slot, so a full queue may still take a push
    // in the same cycle; reset and flush suppress both requests.
    always_comb begin
        active  = CLR && !flush;
        rtr_ok  = active && rtr && !vazio;
        push_ok = active && adc && (!cheio || rtr_ok);
    end

    // Storage array is written without reset so stale entries may remain.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[tras] <= instrIn;
    end

    // Pointers, occupancy, output register and sticky error flags.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            frente   <= '0;
            tras     <= '0;
            ocup     <= '0;
            instrOut <= '0;
            outValid <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else if (flush) begin
            frente   <= '0;
            tras     <= '0;
            ocup     <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= rtr_ok;
            if (rtr_ok) begin
                instrOut <= mem[frente];
                frente   <= frente + 1'b1;
            end
            if (push_ok)
                tras <= tras + 1'b1;
            case ({push_ok, rtr_ok})
                2'b10:   ocup <= ocup + 1'b1;
                2'b01:   ocup <= ocup - 1'b1;
                default: ocup <= ocup;
            endcase
            if (adc && cheio && !rtr_ok)
                ovf <= 1'b1;
            if (rtr && vazio)
                udf <= 1'b1;
        end
    end

endmodule
